// File: rtl/ball_motion_ctrl.sv
// Ball sprite motion controller: once per frame it advances the ball, bounces it off
// walls and paddles, runs the serve countdown and pulses a score event on a miss.
module ball_motion_ctrl #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int BALL_SIZE    = 8,
  parameter int SPEED        = 2,
  parameter int START_X      = 316,
  parameter int START_Y      = 236,
  parameter int SERVE_FRAMES = 4,
  parameter int X_POS_W      = 10,
  parameter int Y_POS_W      = 10
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               frame_tick_i,
  input  logic               game_en_i,
  input  logic               on_ball_i,
  input  logic               on_paddle_l_i,
  input  logic               on_paddle_r_i,
  output logic [X_POS_W-1:0] x_pos_o,
  output logic [Y_POS_W-1:0] y_pos_o,
  output logic [X_POS_W-1:0] right_o,
  output logic [Y_POS_W-1:0] bottom_o,
  output logic               score_l_o,
  output logic               score_r_o
);

  localparam int CNT_W = (SERVE_FRAMES < 1) ? 1 : $clog2(SERVE_FRAMES + 1);

  localparam logic [X_POS_W-1:0] X_START = X_POS_W'(START_X);
  localparam logic [X_POS_W-1:0] X_SIZE  = X_POS_W'(BALL_SIZE);
  localparam logic [X_POS_W-1:0] X_STEP  = X_POS_W'(SPEED);
  localparam logic [Y_POS_W-1:0] Y_START = Y_POS_W'(START_Y);
  localparam logic [Y_POS_W-1:0] Y_SIZE  = Y_POS_W'(BALL_SIZE);
  localparam logic [Y_POS_W-1:0] Y_STEP  = Y_POS_W'(SPEED);
  localparam logic [Y_POS_W-1:0] Y_BOT   = Y_POS_W'(SCREEN_H - 1 - BALL_SIZE);

  // Boundary tests run one bit wider so x + size + step can never wrap.
  localparam logic [X_POS_W:0] XE_SIZE   = (X_POS_W+1)'(BALL_SIZE);
  localparam logic [X_POS_W:0] XE_STEP   = (X_POS_W+1)'(SPEED);
  localparam logic [X_POS_W:0] XE_SCREEN = (X_POS_W+1)'(SCREEN_W);
  localparam logic [Y_POS_W:0] YE_SIZE   = (Y_POS_W+1)'(BALL_SIZE);
  localparam logic [Y_POS_W:0] YE_STEP   = (Y_POS_W+1)'(SPEED);
  localparam logic [Y_POS_W:0] YE_SCREEN = (Y_POS_W+1)'(SCREEN_H);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_MOVE  = 2'd1,
    ST_SCORE = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [X_POS_W-1:0] r_x;
  logic [X_POS_W-1:0] r_right;
  logic [Y_POS_W-1:0] r_y;
  logic [Y_POS_W-1:0] r_bottom;
  logic               r_dir_x;   // 1 = right
  logic               r_dir_y;   // 1 = down
  logic               r_hit_l;
  logic               r_hit_r;
  logic               r_score_l;
  logic               r_score_r;

  logic               w_adv;
  logic               w_dir_x;
  logic               w_dir_y;
  logic               w_miss_l;
  logic               w_miss_r;
  logic [X_POS_W-1:0] w_x_nx;
  logic [Y_POS_W-1:0] w_y_nx;
  logic [X_POS_W:0]   w_x_ext;
  logic [Y_POS_W:0]   w_y_ext;

  assign w_adv   = frame_tick_i & game_en_i;
  assign w_x_ext = {1'b0, r_x};
  assign w_y_ext = {1'b0, r_y};

  // A paddle only reflects the ball when it is travelling toward that paddle.
  always_comb begin
    w_dir_x = r_dir_x;
    if (r_hit_l && !r_dir_x)
      w_dir_x = 1'b1;
    else if (r_hit_r && r_dir_x)
      w_dir_x = 1'b0;
  end

  always_comb begin
    w_y_nx  = r_y;
    w_dir_y = r_dir_y;
    if (!r_dir_y) begin
      if (w_y_ext < YE_STEP) begin
        w_y_nx  = '0;
        w_dir_y = 1'b1;
      end else begin
        w_y_nx = r_y - Y_STEP;
      end
    end else begin
      if (w_y_ext + YE_SIZE + YE_STEP >= YE_SCREEN) begin
        w_y_nx  = Y_BOT;
        w_dir_y = 1'b0;
      end else begin
        w_y_nx = r_y + Y_STEP;
      end
    end
  end

  always_comb begin
    w_x_nx   = r_x;
    w_miss_l = 1'b0;
    w_miss_r = 1'b0;
    if (!w_dir_x) begin
      if (w_x_ext < XE_STEP)
        w_miss_l = 1'b1;
      else
        w_x_nx = r_x - X_STEP;
    end else begin
      if (w_x_ext + XE_SIZE + XE_STEP >= XE_SCREEN)
        w_miss_r = 1'b1;
      else
        w_x_nx = r_x + X_STEP;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_SERVE;
      r_cnt     <= CNT_LOAD;
      r_x       <= X_START;
      r_right   <= X_START + X_SIZE;
      r_y       <= Y_START;
      r_bottom  <= Y_START + Y_SIZE;
      r_dir_x   <= 1'b1;
      r_dir_y   <= 1'b1;
      r_hit_l   <= 1'b0;
      r_hit_r   <= 1'b0;
      r_score_l <= 1'b0;
      r_score_r <= 1'b0;
    end else begin
      // A hit coinciding with a tick belongs to the next frame.
      if (on_ball_i && on_paddle_l_i)
        r_hit_l <= 1'b1;
      else if (frame_tick_i)
        r_hit_l <= 1'b0;
      if (on_ball_i && on_paddle_r_i)
        r_hit_r <= 1'b1;
      else if (frame_tick_i)
        r_hit_r <= 1'b0;

      r_score_l <= 1'b0;
      r_score_r <= 1'b0;

      case (r_state)
        ST_SERVE: begin
          if (w_adv) begin
            if (r_cnt == '0)
              r_state <= ST_MOVE;
            else
              r_cnt <= r_cnt - CNT_ONE;
          end
        end
        ST_MOVE: begin
          if (w_adv) begin
            if (w_miss_l || w_miss_r) begin
              // Re-serve toward the side that conceded; dir_y is kept.
              r_state   <= ST_SCORE;
              r_score_r <= w_miss_l;
              r_score_l <= w_miss_r;
              r_dir_x   <= w_miss_r;
              r_cnt     <= CNT_LOAD;
              r_x       <= X_START;
              r_right   <= X_START + X_SIZE;
              r_y       <= Y_START;
              r_bottom  <= Y_START + Y_SIZE;
            end else begin
              r_dir_x  <= w_dir_x;
              r_dir_y  <= w_dir_y;
              r_x      <= w_x_nx;
              r_right  <= w_x_nx + X_SIZE;
              r_y      <= w_y_nx;
              r_bottom <= w_y_nx + Y_SIZE;
            end
          end
        end
        ST_SCORE: r_state <= ST_SERVE;
        default:  r_state <= ST_SERVE;
      endcase
    end
  end

  assign x_pos_o   = r_x;
  assign y_pos_o   = r_y;
  assign right_o   = r_right;
  assign bottom_o  = r_bottom;
  assign score_l_o = r_score_l;
  assign score_r_o = r_score_r;

endmodule

// File: doc/ball_motion_ctrl.md
Name: ball_motion_ctrl

Overview:
- Frame-rate controller for the ball sprite. Once per frame it computes the ball's position and bounding box, which feed the sprite_if consumed by the sprite renderer.
- Samples the renderer's on_sprite outputs (ball, left paddle, right paddle) during the active frame to detect paddle hits.
- Handles wall bounces, serve delay and point detection, and pulses score events to the scoreboard logic.

Parameters:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- BALL_SIZE, 8, ball edge length; right = x + BALL_SIZE, bottom = y + BALL_SIZE
- SPEED, 2, pixels moved per frame on each axis
- START_X, 316, serve x position
- START_Y, 236, serve y position
- SERVE_FRAMES, 4, serve countdown load value
- X_POS_W, 10, x coordinate width (vga_pkg)
- Y_POS_W, 10, y coordinate width (vga_pkg)

Ports:
- clk_i  in  1  pixel clock
- rst_ni  in  1  asynchronous active-low reset
- frame_tick_i  in  1  one-cycle pulse per frame, during vblank
- game_en_i  in  1  1 = run, 0 = pause/hold serve
- on_ball_i  in  1  ball sprite pixel hit (registered on_sprite_o)
- on_paddle_l_i  in  1  left paddle pixel hit
- on_paddle_r_i  in  1  right paddle pixel hit
- x_pos_o  out  X_POS_W  ball left edge
- y_pos_o  out  Y_POS_W  ball top edge
- right_o  out  X_POS_W  x_pos_o + BALL_SIZE
- bottom_o  out  Y_POS_W  y_pos_o + BALL_SIZE
- score_l_o  out  1  one-cycle pulse: left player scored
- score_r_o  out  1  one-cycle pulse: right player scored

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low. All state is in flops.
- Reset values (take effect immediately, no clock needed):
  - x = START_X, y = START_Y, right/bottom consistent with them
  - dir_x = right (1), dir_y = down (1)
  - state SERVE, serve counter = SERVE_FRAMES
  - hit latches 0, score pulses 0
- Hit latches:
  - hit_l set when on_ball_i & on_paddle_l_i in the same cycle; hit_r likewise with on_paddle_r_i.
  - Both latches clear on every frame_tick_i, in any state.
  - A hit in the same cycle as a tick wins: the latch is set (next frame's value). The tick uses the previous latch value.
- Timing: all outputs are registered and update on the edge that samples frame_tick_i, i.e. latency 1 cycle from the tick. right_o/bottom_o always match x/y in the same cycle.
- State SERVE:
  - On a tick with game_en_i = 1: counter == 0 -> MOVE, with no motion on that tick; otherwise counter decrements.
  - game_en_i = 0: counter and position hold.
- State MOVE: on a tick with game_en_i = 1, apply the rules below in this order. game_en_i = 0 ignores ticks (pause), but the latches still clear.
  1. X direction:
     - hit_l & dir_x = left -> dir_x = right.
     - hit_r & dir_x = right -> dir_x = left.
     - A hit against the direction of travel is ignored.
     - The new dir_x is used for this tick's move.
  2. Y axis:
     - Up: y < SPEED -> y = 0, dir_y = down; else y -= SPEED.
     - Down: y + BALL_SIZE + SPEED >= SCREEN_H -> y = SCREEN_H - 1 - BALL_SIZE, dir_y = up; else y += SPEED.
  3. X axis:
     - Left: x < SPEED -> miss on the left; right player scores.
     - Right: x + BALL_SIZE + SPEED >= SCREEN_W -> miss on the right; left player scores.
     - Otherwise x moves by ±SPEED.
  - All comparisons are done at width+1 bits; no wrap-around.
- Miss (on the same edge):
  - state -> SCORE; the corresponding score_*_o goes high.
  - x/y = START values, dir_y unchanged.
  - dir_x points toward the player who conceded.
  - counter = SERVE_FRAMES.
- State SCORE: lasts exactly one cycle; score pulse deasserts; -> SERVE. A tick arriving during SCORE is ignored.
- Mutual exclusion: score_l_o and score_r_o are never high together.
- Reset mid-operation: asynchronous return to reset values from any state. No score pulse is emitted.

Test Plan:
- Reset and serve: deassert rst_ni, game_en_i = 1.
  - Expect x/y/right/bottom = 316/236/324/244, both scores 0.
  - Ticks 1–4 change no position; tick 5 enters MOVE with no motion.
  - Tick 6 gives x = 318, y = 238, one cycle after the tick.
- Bottom bounce: run down-right with no hits.
  - y steps 236, 238, …, 470, then clamps to 471 with dir_y = up; next tick y = 469.
- Paddle hit: while dir_x = right, pulse on_ball_i & on_paddle_r_i for 1 cycle at x = 400, then tick.
  - Expect x = 398.
  - Repeat with on_paddle_l_i instead: expect x = 402 (ignored).
  - Hit coincident with a tick: applied on the following tick.
- Right miss: no hits; the ball reaches x = 630 and the next tick is taken.
  - score_l_o high exactly 1 cycle; x/y = 316/236; dir_x = right.
  - SERVE countdown restarts from 4; score_r_o stays 0.
- Pause: game_en_i = 0 in MOVE for 10 ticks.
  - Position frozen; hits latched before the pause do not flip dir_x after resume (cleared by the ticks).
- Async reset: assert rst_ni low between clock edges while in MOVE at x = 500.
  - Outputs return to 316/236/324/244 before the next edge; no score pulse.
